// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM wordline pulse sequencer.
package rram_pkg;

    localparam logic [1:0] MODE_NOP   = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_SET   = 2'b10;
    localparam logic [1:0] MODE_RESET = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        PULSE   = 2'b10,
        RECOVER = 2'b11
    } state_t;

endpackage

// File: rtl/wl_onehot_dec.sv
// Generalised row decoder: one-hot wordline select, all-zero when disabled
// or when the address is beyond the populated rows.
module wl_onehot_dec #(
    parameter int ADDR_W = 5,
    parameter int NUM_WL = 32
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NUM_WL-1:0] wl_o
);

    // Compare against every populated row so out-of-range addresses match nothing.
    always_comb begin
        wl_o = '0;
        for (int unsigned i = 0; i < NUM_WL; i++) begin
            wl_o[i] = en_i && (addr_i == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/rram_wl_pulse_sequencer.sv
// Wordline pulse sequencer: latches one row request, then drives mode setup,
// a one-hot wordline pulse of programmable length and a recovery gap.
module rram_wl_pulse_sequencer
    import rram_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int NUM_WL    = 32,
    parameter int PULSE_W   = 8,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [1:0]         req_mode,
    input  logic [PULSE_W-1:0] req_len,
    output logic [NUM_WL-1:0]  wl,
    output logic [1:0]         mode_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PHASE_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int CNT_W     = (PULSE_W > PHASE_W) ? PULSE_W : PHASE_W;
    localparam logic [ADDR_W:0] NUM_WL_EXT = (ADDR_W + 1)'(NUM_WL);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         mode_q, mode_d;
    logic [PULSE_W-1:0] len_q, len_d;
    logic [NUM_WL-1:0]  wl_q, wl_d;
    logic [1:0]         mode_out_q, mode_out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept, illegal;

    assign req_ready = en && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wl        = wl_q;
    assign mode_out  = mode_out_q;
    assign done      = done_q;
    assign err       = err_q;

    assign accept  = req_valid && req_ready;
    assign illegal = ({1'b0, req_addr} >= NUM_WL_EXT) || (req_len == '0) || (req_mode == MODE_NOP);
    assign cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

    // Wordline drive is decoded from the next state so it is registered
    // alongside the state and can never be high outside PULSE.
    wl_onehot_dec #(
        .ADDR_W (ADDR_W),
        .NUM_WL (NUM_WL)
    ) u_dec (
        .en_i   (state_d == PULSE),
        .addr_i (addr_d),
        .wl_o   (wl_d)
    );

    // Next-state, counter reload, request latch and output pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q != IDLE && !en) begin
            // Abort takes priority, so a final RECOVER cycle yields err without done.
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = SETUP;
                            cnt_d   = CNT_W'(SETUP_CYC - 1);
                            addr_d  = req_addr;
                            mode_d  = req_mode;
                            len_d   = req_len;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_d = PULSE;
                        cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_d = RECOVER;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        mode_out_d = (state_d != IDLE) ? mode_d : MODE_NOP;
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            mode_q     <= MODE_NOP;
            len_q      <= '0;
            wl_q       <= '0;
            mode_out_q <= MODE_NOP;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            wl_q       <= wl_d;
            mode_out_q <= mode_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_rram_wl_pulse_sequencer.sv
// Self-checking bench for rram_wl_pulse_sequencer: per-scenario tasks plus a
// scoreboard of expected done/err events keyed by cycle.
module tb_rram_wl_pulse_sequencer;
    import rram_pkg::*;

    localparam int SETUP = 2;
    localparam int GAP   = 2;

    typedef struct {
        bit          is_err;
        int unsigned cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_addr = '0;
    logic [1:0]  req_mode = '0;
    logic [7:0]  req_len  = '0;
    logic [31:0] wl;
    logic [1:0]  mode_out;
    logic        busy, done, err;

    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic [5:0]  b_req_addr = '0;
    logic [1:0]  b_req_mode = '0;
    logic [7:0]  b_req_len  = '0;
    logic [39:0] b_wl;
    logic [1:0]  b_mode_out;
    logic        b_busy, b_done, b_err;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    ev_t         sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rram_wl_pulse_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mode(req_mode), .req_len(req_len), .wl(wl),
        .mode_out(mode_out), .busy(busy), .done(done), .err(err)
    );

    rram_wl_pulse_sequencer #(.ADDR_W(6), .NUM_WL(40)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_mode(b_req_mode), .req_len(b_req_len), .wl(b_wl),
        .mode_out(b_mode_out), .busy(b_busy), .done(b_done), .err(b_err)
    );

    // Invariants every cycle, and done/err events popped against the scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            n_cmp++;
            if (!$onehot0(wl) || (done && err) || (wl != '0 && (!busy || mode_out == MODE_NOP))) begin
                n_bad++;
                $display("FAIL invariant cyc=%0d: wl=%h mode_out=%b busy=%b done=%b err=%b", cyc, wl, mode_out, busy, done, err);
            end
            if (done || err) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d: got done=%b err=%b, want none", cyc, done, err);
                end else begin
                    ev = sb.pop_front();
                    if (ev.is_err !== err || ev.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL event: got err=%b at cyc %0d, want err=%b at cyc %0d", err, cyc, ev.is_err, ev.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Legal request on dut: drive at current negedge, check every cycle to done.
    task automatic run_legal(input logic [4:0] a, input logic [1:0] m, input int unsigned len);
        int unsigned total;
        logic [31:0] exp_wl;
        logic [1:0]  exp_mode;
        logic        exp_busy;
        ev_t         ev;
        total = SETUP + len + GAP + 1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_mode = m; req_len = 8'(len);
        ev.is_err = 1'b0; ev.cyc = cyc + total;
        sb.push_back(ev);
        for (int unsigned k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; req_addr = 5'($urandom); req_mode = 2'($urandom); req_len = 8'($urandom);
            end
            exp_wl   = (k > SETUP && k <= SETUP + len) ? (32'd1 << a) : '0;
            exp_mode = (k < total) ? m : MODE_NOP;
            exp_busy = (k < total);
            n_cmp += 3;
            if (wl !== exp_wl) begin
                n_bad++;
                $display("FAIL wl k=%0d: got %h want %h", k, wl, exp_wl);
            end
            if (mode_out !== exp_mode) begin
                n_bad++;
                $display("FAIL mode_out k=%0d: got %b want %b", k, mode_out, exp_mode);
            end
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy k=%0d: got %b want %b", k, busy, exp_busy);
            end
        end
    endtask

    // Illegal request on dut: err next cycle, nothing else moves.
    task automatic run_reject(input logic [4:0] a, input logic [1:0] m, input logic [7:0] len);
        ev_t ev;
        req_valid = 1'b1; req_addr = a; req_mode = m; req_len = len;
        ev.is_err = 1'b1; ev.cyc = cyc + 1;
        sb.push_back(ev);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp += 4;
        if (wl !== '0) begin n_bad++; $display("FAIL reject_wl: got %h want 0", wl); end
        if (mode_out !== MODE_NOP) begin n_bad++; $display("FAIL reject_mode: got %b want 00", mode_out); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy: got %b want 0", busy); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reject_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (wl !== '0) begin n_bad++; $display("FAIL rst_wl: got %h want 0", wl); end
        if (mode_out !== 2'b00) begin n_bad++; $display("FAIL rst_mode: got %b want 00", mode_out); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        run_legal(5'd5, MODE_READ, 3);
        @(negedge clk);
    endtask

    task automatic test_reject();
        run_reject(5'd4, MODE_SET, 8'd0);
        run_reject(5'd4, MODE_NOP, 8'd5);
        // Wide instance: row 40 does not exist, row 39 does.
        n_cmp++;
        if (b_req_ready !== 1'b1) begin n_bad++; $display("FAIL b_ready_before: got %b want 1", b_req_ready); end
        b_req_valid = 1'b1; b_req_addr = 6'd40; b_req_mode = MODE_READ; b_req_len = 8'd5;
        @(negedge clk);
        b_req_valid = 1'b0;
        n_cmp += 4;
        if (b_err !== 1'b1) begin n_bad++; $display("FAIL b_reject_err: got %b want 1", b_err); end
        if (b_wl !== '0) begin n_bad++; $display("FAIL b_reject_wl: got %h want 0", b_wl); end
        if (b_busy !== 1'b0) begin n_bad++; $display("FAIL b_reject_busy: got %b want 0", b_busy); end
        if (b_req_ready !== 1'b1) begin n_bad++; $display("FAIL b_reject_ready: got %b want 1", b_req_ready); end
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = 6'd39; b_req_mode = MODE_SET; b_req_len = 8'd1;
        for (int unsigned k = 1; k <= 6; k++) begin
            @(negedge clk);
            b_req_valid = 1'b0;
            if (k == 3) begin
                n_cmp++;
                if (b_wl !== (40'd1 << 39)) begin n_bad++; $display("FAIL b_wl39: got %h want %h", b_wl, 40'd1 << 39); end
            end
            if (k == 6) begin
                n_cmp++;
                if (b_done !== 1'b1) begin n_bad++; $display("FAIL b_done: got %b want 1", b_done); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        ev_t ev;
        req_valid = 1'b1; req_addr = 5'd31; req_mode = MODE_SET; req_len = 8'd10;
        for (int unsigned k = 1; k <= SETUP + 2; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        n_cmp++;
        if (wl !== (32'd1 << 31)) begin n_bad++; $display("FAIL abort_pulse_wl: got %h want 80000000", wl); end
        en = 1'b0;
        ev.is_err = 1'b1; ev.cyc = cyc + 1;
        sb.push_back(ev);
        @(negedge clk);
        n_cmp += 4;
        if (wl !== '0) begin n_bad++; $display("FAIL abort_wl: got %h want 0", wl); end
        if (mode_out !== MODE_NOP) begin n_bad++; $display("FAIL abort_mode: got %b want 00", mode_out); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", req_ready); end
        req_valid = 1'b1; req_addr = 5'd1; req_mode = MODE_READ; req_len = 8'd2;
        repeat (2) begin
            @(negedge clk);
            n_cmp += 2;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL en_low_busy: got %b want 0", busy); end
            if (req_ready !== 1'b0) begin n_bad++; $display("FAIL en_low_ready: got %b want 0", req_ready); end
        end
        req_valid = 1'b0; en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL en_back_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        run_legal(5'd0, MODE_RESET, 1);
        @(negedge clk);
        run_legal(5'd31, MODE_RESET, 255);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 5'd3; req_mode = MODE_SET; req_len = 8'd20;
        for (int unsigned k = 1; k <= SETUP + 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 6;
        if (wl !== '0) begin n_bad++; $display("FAIL mid_rst_wl: got %h want 0", wl); end
        if (mode_out !== 2'b00) begin n_bad++; $display("FAIL mid_rst_mode: got %b want 00", mode_out); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", done); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", err); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
        rst = 1'b0;
        @(negedge clk);
        run_legal(5'd7, MODE_READ, 4);
    endtask

    task automatic test_random();
        logic [4:0] a;
        logic [1:0] m;
        int unsigned len;
        for (int unsigned i = 0; i < 24; i++) begin
            a = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: run_reject(a, MODE_NOP, 8'($urandom_range(1, 255)));
                1: run_reject(a, 2'($urandom_range(1, 3)), 8'd0);
                default: begin
                    m = 2'($urandom_range(1, 3));
                    len = $urandom_range(1, 12);
                    run_legal(a, m, len);
                end
            endcase
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_reject();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d outstanding want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
